// File: rtl/fmap_pkg.sv
// Shared types and helpers for the 4-channel feature-map collector.
package fmap_pkg;
    localparam int NCH = 4;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic int calc_aw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/fmap_collector_4ch_if.sv
// Pixel-in / planar-word-out bus of the feature-map collector.
interface fmap_collector_4ch_if #(
    parameter int Datawidth = 32,
    parameter int AW        = 4
);
    logic                 valid_in;
    logic [Datawidth-1:0] In_0, In_1, In_2, In_3;
    logic                 in_ready;
    logic                 valid_out;
    logic                 ready_in;
    logic [Datawidth-1:0] Out;
    logic [1:0]           out_ch;
    logic [AW-1:0]        out_idx;
    logic                 last_out;
    logic                 overflow;

    modport master (
        output valid_in, In_0, In_1, In_2, In_3, ready_in,
        input  in_ready, valid_out, Out, out_ch, out_idx, last_out, overflow
    );
    modport slave (
        input  valid_in, In_0, In_1, In_2, In_3, ready_in,
        output in_ready, valid_out, Out, out_ch, out_idx, last_out, overflow
    );
endinterface

// File: rtl/fmap_bank.sv
// One channel bank: synchronous write, combinational read.
module fmap_bank #(
    parameter int N         = 9,
    parameter int Datawidth = 32,
    parameter int AW        = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [Datawidth-1:0] wdata,
    input  logic [AW-1:0]        raddr,
    output logic [Datawidth-1:0] rdata
);
    logic [Datawidth-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fmap_collector_4ch.sv
// Captures a frame of 4-channel pixels, then drains it channel-major over valid/ready.
module fmap_collector_4ch
    import fmap_pkg::*;
#(
    parameter int IMG_Width  = 3,
    parameter int IMG_Height = 3,
    parameter int Datawidth  = 32
) (
    input logic               clk,
    input logic               rst,
    fmap_collector_4ch_if.slave bus
);
    localparam int N  = IMG_Width * IMG_Height;
    localparam int AW = calc_aw(N);

    localparam logic [1:0] FILL  = ST_FILL;
    localparam logic [1:0] LOAD  = ST_LOAD;
    localparam logic [1:0] DRAIN = ST_DRAIN;

    logic [1:0]                         state;
    logic [AW-1:0]                      wr_idx;
    logic [AW-1:0]                      nxt_idx;
    logic [1:0]                         nxt_ch;
    logic [NCH-1:0][Datawidth-1:0]      wr_data;
    logic [NCH-1:0][Datawidth-1:0]      rd_data;
    logic                               wr_en;
    logic                               hs;

    logic                 vout_q, last_q, ovf_q;
    logic [Datawidth-1:0] out_q;
    logic [1:0]           ch_q;
    logic [AW-1:0]        idx_q;

    assign wr_data = {bus.In_3, bus.In_2, bus.In_1, bus.In_0};
    assign wr_en   = bus.valid_in && (state == FILL);
    assign hs      = vout_q && bus.ready_in;

    // Read address is the word that will be registered at the next edge.
    always_comb begin
        nxt_ch  = '0;
        nxt_idx = '0;
        if (state != LOAD) begin
            if (idx_q == AW'(N - 1)) begin
                nxt_ch  = ch_q + 2'd1;
                nxt_idx = '0;
            end else begin
                nxt_ch  = ch_q;
                nxt_idx = idx_q + AW'(1);
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_bank
        fmap_bank #(.N(N), .Datawidth(Datawidth), .AW(AW)) u_bank (
            .clk   (clk),
            .we    (wr_en),
            .waddr (wr_idx),
            .wdata (wr_data[g]),
            .raddr (nxt_idx),
            .rdata (rd_data[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FILL;
            wr_idx <= '0;
            vout_q <= 1'b0;
            out_q  <= '0;
            ch_q   <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (bus.valid_in && state != FILL) ovf_q <= 1'b1;
            case (state)
                FILL: if (bus.valid_in) begin
                    if (wr_idx == AW'(N - 1)) begin
                        wr_idx <= '0;
                        state  <= LOAD;
                    end else begin
                        wr_idx <= wr_idx + AW'(1);
                    end
                end
                LOAD, DRAIN: begin
                    if (state == LOAD || (hs && !last_q)) begin
                        out_q  <= rd_data[nxt_ch];
                        ch_q   <= nxt_ch;
                        idx_q  <= nxt_idx;
                        last_q <= (nxt_ch == 2'(NCH - 1)) && (nxt_idx == AW'(N - 1));
                        vout_q <= 1'b1;
                        state  <= DRAIN;
                    end else if (hs) begin
                        vout_q <= 1'b0;
                        last_q <= 1'b0;
                        state  <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.in_ready  = (state == FILL);
    assign bus.valid_out = vout_q;
    assign bus.Out       = out_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_idx   = idx_q;
    assign bus.last_out  = last_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_fmap_collector_4ch.sv
// Randomized bench for fmap_collector_4ch against a frame/queue reference model.
module tb_fmap_collector_4ch;
    localparam int N  = 9;
    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] d;
        int            ch;
        int            idx;
        bit            last;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fmap_collector_4ch_if #(.Datawidth(DW), .AW(4)) bus();

    fmap_collector_4ch #(.IMG_Width(3), .IMG_Height(3), .Datawidth(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: pixels captured so far, and the planar words still owed.
    logic [3:0][DW-1:0] pix_q[$];
    word_t              exp_q[$];
    bit                 m_fill = 1'b1;
    bit                 m_load = 1'b0;
    bit                 m_ovf  = 1'b0;
    int                 m_pops = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input bit v, input logic [3:0][DW-1:0] d, input bit rdy, input bit rs);
        bit was_fill, vout;
        word_t w;
        rst          = rs;
        bus.valid_in = v;
        bus.In_0     = d[0];
        bus.In_1     = d[1];
        bus.In_2     = d[2];
        bus.In_3     = d[3];
        bus.ready_in = rdy;

        was_fill = m_fill;
        vout     = (exp_q.size() != 0) && !m_load;
        if (rs) begin
            pix_q.delete();
            exp_q.delete();
            m_fill = 1'b1;
            m_load = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_load = 1'b0;
            if (vout && rdy) begin
                w = exp_q.pop_front();
                m_pops++;
                if (w.last) m_fill = 1'b1;
            end
            if (v) begin
                if (was_fill) begin
                    pix_q.push_back(d);
                    if (pix_q.size() == N) begin
                        for (int c = 0; c < 4; c++)
                            for (int i = 0; i < N; i++) begin
                                w.d    = pix_q[i][c];
                                w.ch   = c;
                                w.idx  = i;
                                w.last = (c == 3) && (i == N - 1);
                                exp_q.push_back(w);
                            end
                        pix_q.delete();
                        m_fill = 1'b0;
                        m_load = 1'b1;
                    end
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end

        @(posedge clk);
        @(negedge clk);
        vout = (exp_q.size() != 0) && !m_load;
        chk("in_ready", 64'(bus.in_ready), 64'(m_fill));
        chk("overflow", 64'(bus.overflow), 64'(m_ovf));
        chk("valid_out", 64'(bus.valid_out), 64'(vout));
        if (vout) begin
            chk("Out", 64'(bus.Out), 64'(exp_q[0].d));
            chk("out_ch", 64'(bus.out_ch), 64'(exp_q[0].ch));
            chk("out_idx", 64'(bus.out_idx), 64'(exp_q[0].idx));
            chk("last_out", 64'(bus.last_out), 64'(exp_q[0].last));
        end
        if (rs) begin
            chk("rst_Out", 64'(bus.Out), 64'd0);
            chk("rst_out_ch", 64'(bus.out_ch), 64'd0);
            chk("rst_out_idx", 64'(bus.out_idx), 64'd0);
            chk("rst_last", 64'(bus.last_out), 64'd0);
        end
    endtask

    task automatic feed(input int npix, input int gap, input bit pat);
        int p = 0;
        for (int c = 0; c < 2000 && p < npix && m_fill; c++) begin
            logic [3:0][DW-1:0] d;
            bit v;
            v = (c % gap) == 0;
            for (int k = 0; k < 4; k++) d[k] = pat ? DW'(16 * k + p) : DW'($urandom);
            cycle(v, d, 1'b1, 1'b0);
            if (v) p++;
        end
        chk("feed_timeout", 64'(p), 64'(npix));
    endtask

    task automatic drain(input int rmode, input bit inject, input int max_words);
        logic [3:0][DW-1:0] dead;
        int start = m_pops;
        int c;
        for (int k = 0; k < 4; k++) dead[k] = 32'hDEAD;
        for (c = 0; c < 1000 && !m_fill && (m_pops - start) < max_words; c++) begin
            bit rdy, v;
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (c % 3) == 0;
                default: rdy = $urandom_range(0, 1) == 1;
            endcase
            v = inject && ($urandom_range(0, 3) == 0);
            cycle(v, dead, rdy, 1'b0);
        end
        if (c >= 1000) chk("drain_timeout", 64'(c), 64'd0);
    endtask

    initial begin
        logic [3:0][DW-1:0] z;
        z = '0;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b0;
        bus.In_0 = '0; bus.In_1 = '0; bus.In_2 = '0; bus.In_3 = '0;

        cycle(1'b0, z, 1'b0, 1'b1);
        cycle(1'b0, z, 1'b0, 1'b1);

        // Counting-pattern frame, full-rate drain.
        feed(N, 1, 1'b1);
        drain(0, 1'b0, 4 * N);
        cycle(1'b0, z, 1'b1, 1'b0);

        // Same frame with ready_in 1,0,0 repeating.
        feed(N, 1, 1'b1);
        drain(1, 1'b0, 4 * N);

        // Gapped capture.
        feed(N, 3, 1'b0);
        drain(2, 1'b0, 4 * N);

        // Pixels arriving during drain are dropped and flag overflow.
        feed(N, 1, 1'b0);
        drain(0, 1'b1, 4 * N);
        feed(N, 1, 1'b0);
        drain(2, 1'b0, 4 * N);

        // Reset after a partial frame.
        feed(5, 1, 1'b0);
        cycle(1'b0, z, 1'b1, 1'b1);
        feed(N, 1, 1'b1);
        drain(0, 1'b0, 4 * N);

        // Reset mid-drain after 10 words.
        feed(N, 1, 1'b0);
        drain(0, 1'b0, 10);
        cycle(1'b0, z, 1'b1, 1'b1);
        feed(N, 1, 1'b0);
        drain(0, 1'b0, 4 * N);

        // Free-running random traffic, including pixels during LOAD and final handshake.
        for (int c = 0; c < 400; c++) begin
            logic [3:0][DW-1:0] d;
            for (int k = 0; k < 4; k++) d[k] = DW'($urandom);
            cycle($urandom_range(0, 9) < 6, d, $urandom_range(0, 3) != 0, 1'b0);
        end
        drain(0, 1'b0, 4 * N);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
